// File: rtl/imem_loader.sv
// Byte-stream loader: assembles big-endian words into instruction memory, XOR-checksummed; holds CPU until a clean load.
// Latency: word write strobe registered on the 4th-byte edge; in_ready stays high all session (1 byte/cycle).
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM} state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic [7:0]  xor_acc;
  logic        ovf;

  logic accept;
  logic load_bad;
  assign accept   = in_valid && in_ready;
  assign load_bad = (in_data != xor_acc) || ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_adr   <= BASE_ADDR;
      mem_data  <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      xor_acc   <= '0;
      ovf       <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CNT_HI;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            xor_acc  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            ovf      <= 1'b0;
          end
        end
        S_CNT_HI: begin
          if (accept) begin
            n_words[15:8] <= in_data;
            xor_acc       <= xor_acc ^ in_data;
            state         <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            n_words[7:0] <= in_data;
            xor_acc      <= xor_acc ^ in_data;
            state        <= ({n_words[15:8], in_data} != 16'd0) ? S_DATA : S_CSUM;
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_acc  <= xor_acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3) begin
              shreg <= {shreg[15:0], in_data};
            end else begin
              // Words beyond memory capacity are still consumed so the checksum stays aligned.
              if ({1'b0, word_idx} < MAX_W) begin
                mem_data  <= {shreg, in_data};
                mem_adr   <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                mem_wr_en <= 1'b1;
                word_cnt  <= word_cnt + 16'd1;
              end else begin
                ovf <= 1'b1;
              end
              word_idx <= word_idx + 16'd1;
              if (word_idx == n_words - 16'd1) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            err      <= load_bad;
            cpu_hold <= load_bad;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Drives directed and random load sessions into two loaders (normal and 1-word capacity)
// and checks writes and completion status against a stream-level reference model.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [15:0] cnt;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        rdy   [2];
  logic        wr    [2];
  logic [31:0] adr   [2];
  logic [31:0] dat   [2];
  logic        hold  [2];
  logic        bsy   [2];
  logic        dne   [2];
  logic        er    [2];
  logic [15:0] cnt   [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] stim[$];
  wr_t        obs0[$];
  wr_t        obs1[$];

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .mem_wr_en(wr[0]), .mem_adr(adr[0]), .mem_data(dat[0]),
    .cpu_hold(hold[0]), .busy(bsy[0]), .done(dne[0]), .err(er[0]), .word_cnt(cnt[0])
  );

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(1)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .mem_wr_en(wr[1]), .mem_adr(adr[1]), .mem_data(dat[1]),
    .cpu_hold(hold[1]), .busy(bsy[1]), .done(dne[1]), .err(er[1]), .word_cnt(cnt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr[0]) obs0.push_back('{adr: adr[0], dat: dat[0], cnt: cnt[0]});
    if (wr[1]) obs1.push_back('{adr: adr[1], dat: dat[1], cnt: cnt[1]});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_stim(input logic [127:0] v, input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(v[8*(nbytes-1-i) +: 8]);
  endtask

  task automatic check_reset_state(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_in_ready", ph, d), 64'(rdy[d]), 64'd0);
      chk($sformatf("%s_d%0d_wr_en", ph, d), 64'(wr[d]), 64'd0);
      chk($sformatf("%s_d%0d_adr", ph, d), 64'(adr[d]), 64'd0);
      chk($sformatf("%s_d%0d_data", ph, d), 64'(dat[d]), 64'd0);
      chk($sformatf("%s_d%0d_hold", ph, d), 64'(hold[d]), 64'd1);
      chk($sformatf("%s_d%0d_busy", ph, d), 64'(bsy[d]), 64'd0);
      chk($sformatf("%s_d%0d_done", ph, d), 64'(dne[d]), 64'd0);
      chk($sformatf("%s_d%0d_err", ph, d), 64'(er[d]), 64'd0);
      chk($sformatf("%s_d%0d_cnt", ph, d), 64'(cnt[d]), 64'd0);
    end
  endtask

  // Reference: expectations derived purely from the byte stream and memory capacity.
  task automatic score(input string ph, input int d);
    int         n, maxw, nexp, nobs;
    logic [7:0] x;
    logic [31:0] w;
    bit         bad;
    wr_t        o;
    maxw = (d == 0) ? 1024 : 1;
    n    = int'({stim[0], stim[1]});
    x    = 8'h00;
    for (int i = 0; i < stim.size() - 1; i++) x = x ^ stim[i];
    bad  = (x != stim[stim.size()-1]) || (n > maxw);
    nexp = (n < maxw) ? n : maxw;
    nobs = (d == 0) ? obs0.size() : obs1.size();
    chk($sformatf("%s_d%0d_nwrites", ph, d), 64'(nobs), 64'(nexp));
    for (int k = 0; k < nexp && k < nobs; k++) begin
      o = (d == 0) ? obs0[k] : obs1[k];
      w = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
      chk($sformatf("%s_d%0d_w%0d_adr", ph, d, k), 64'(o.adr), 64'(4*k));
      chk($sformatf("%s_d%0d_w%0d_dat", ph, d, k), 64'(o.dat), 64'(w));
      chk($sformatf("%s_d%0d_w%0d_cnt", ph, d, k), 64'(o.cnt), 64'(k+1));
    end
    chk($sformatf("%s_d%0d_done", ph, d), 64'(dne[d]), 64'd1);
    chk($sformatf("%s_d%0d_err", ph, d), 64'(er[d]), 64'(bad));
    chk($sformatf("%s_d%0d_hold", ph, d), 64'(hold[d]), 64'(bad));
    chk($sformatf("%s_d%0d_busy", ph, d), 64'(bsy[d]), 64'd0);
    chk($sformatf("%s_d%0d_in_ready", ph, d), 64'(rdy[d]), 64'd0);
    chk($sformatf("%s_d%0d_word_cnt", ph, d), 64'(cnt[d]), 64'(nexp));
  endtask

  task automatic session(input string ph, input int gap, input bit mid_start, input bit end_start);
    int last;
    last = stim.size() - 1;
    obs0.delete();
    obs1.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({ph, "_busy_on"}, 64'(bsy[0]), 64'd1);
    chk({ph, "_hold_on"}, 64'(hold[0]), 64'd1);
    chk({ph, "_done_clr"}, 64'(dne[0]), 64'd0);
    chk({ph, "_err_clr"}, 64'(er[1]), 64'd0);
    chk({ph, "_cnt_clr"}, 64'(cnt[0]), 64'd0);
    for (int i = 0; i <= last; i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      start    = (mid_start && i == 3) || (end_start && i == last);
      chk($sformatf("%s_in_ready_b%0d", ph, i), 64'({rdy[0], rdy[1]}), 64'd3);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      start    = 1'b0;
      if (i != last) repeat (gap) @(negedge clk);
    end
    score(ph, 0);
    score(ph, 1);
    repeat (2) @(negedge clk);
    chk({ph, "_stay_idle"}, 64'({bsy[0], rdy[0]}), 64'd0);
  endtask

  task automatic random_stream();
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    stim.delete();
    n = $urandom_range(0, 5);
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
    end
    x = 8'h00;
    foreach (stim[i]) x = x ^ stim[i];
    if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
    stim.push_back(x);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load_stim(128'h0002_2008_0005_0008_4020_47, 11);
    session("clean", 0, 1'b0, 1'b0);

    load_stim(128'h0002_2008_0005_0008_4020_46, 11);
    session("badsum", 0, 1'b0, 1'b0);

    load_stim(128'h000000, 3);
    session("n0", 0, 1'b0, 1'b0);

    load_stim(128'h0002_2008_0005_0008_4020_47, 11);
    session("gaps", 3, 1'b1, 1'b0);

    load_stim(128'h0002_2008_0005_0008_4020_47, 11);
    session("end_start", 0, 1'b0, 1'b1);

    // Abort after the second data byte of word 0.
    load_stim(128'h0002_2008_0005_0008_4020_47, 11);
    obs0.delete();
    obs1.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(rdy[0]), 64'd0);
    chk("rst_mid_busy", 64'(bsy[0]), 64'd0);
    chk("rst_mid_hold", 64'(hold[0]), 64'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_writes", 64'(obs0.size() + obs1.size()), 64'd0);
    check_reset_state("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);
    session("after_rst", 0, 1'b0, 1'b0);

    for (int s = 0; s < 12; s++) begin
      random_stream();
      session($sformatf("rand%0d", s), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
